charattr_row_loader: RTL

//  Fills the 88-cell character/attribute row buffer (7-bit write address, 32-bit

---
 rtl/charattr_row_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/charattr_row_loader.sv
// Loads one text row of character/attribute words from video memory into the
// row buffer using burst reads; pulses done once every cell has been written.
module charattr_row_loader #(
  parameter int COLUMNS        = 88,
  parameter int ADDR_WIDTH     = 7,
  parameter int MEM_ADDR_WIDTH = 23,
  parameter int BURST_LEN      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_address,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic                      mem_data_valid,
  input  logic [31:0]               mem_data,
  output logic [ADDR_WIDTH-1:0]     row_addra,
  output logic [31:0]               row_dia,
  output logic                      row_cea
);

  // Column counter carries one extra bit so it can reach COLUMNS itself.
  localparam int CW  = ADDR_WIDTH + 1;
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0]             COLS  = CW'(COLUMNS);
  localparam logic [BCW-1:0]            BLAST = BCW'(BURST_LEN - 1);
  localparam logic [MEM_ADDR_WIDTH-1:0] BSTEP = MEM_ADDR_WIDTH'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_RECEIVE, S_FINISH} state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0]             col_q, col_d;
  logic [BCW-1:0]            burst_q, burst_d;
  logic                      done_q, done_d;
  logic                      row_cea_q, row_cea_d;
  logic [ADDR_WIDTH-1:0]     row_addra_q, row_addra_d;
  logic [31:0]               row_dia_q, row_dia_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      col_q       <= '0;
      burst_q     <= '0;
      done_q      <= 1'b0;
      row_cea_q   <= 1'b0;
      row_addra_q <= '0;
      row_dia_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      col_q       <= col_d;
      burst_q     <= burst_d;
      done_q      <= done_d;
      row_cea_q   <= row_cea_d;
      row_addra_q <= row_addra_d;
      row_dia_q   <= row_dia_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    col_d       = col_q;
    burst_d     = burst_q;
    done_d      = 1'b0;
    row_cea_d   = 1'b0;
    row_addra_d = row_addra_q;
    row_dia_d   = row_dia_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem_addr_d = base_address;
          col_d      = '0;
          burst_d    = '0;
          state_d    = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (mem_ack) begin
          burst_d = '0;
          state_d = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (mem_data_valid) begin
          burst_d = burst_q + 1'b1;
          // Tail words of the last burst beyond the row are dropped.
          if (col_q < COLS) begin
            row_cea_d   = 1'b1;
            row_addra_d = col_q[ADDR_WIDTH-1:0];
            row_dia_d   = mem_data;
            col_d       = col_q + 1'b1;
          end
          if (burst_q == BLAST) begin
            if (col_d < COLS) begin
              mem_addr_d = mem_addr_q + BSTEP;
              state_d    = S_REQUEST;
            end else begin
              state_d    = S_FINISH;
            end
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign mem_req   = (state_q == S_REQUEST);
  assign mem_addr  = mem_addr_q;
  assign done      = done_q;
  assign row_cea   = row_cea_q;
  assign row_addra = row_addra_q;
  assign row_dia   = row_dia_q;

endmodule
